tt_scan_ctrl: RTL and testbench

//  Self-test sequencer for a 4-input combinational logic function (a,b,c,d -> y).
//  On start, drives all 2**N_IN input vectors in order and samples y for each.

---
 rtl/tt_scan_pkg.sv | 23 ++
 rtl/tt_scan_ctrl_if.sv | 33 +++
 rtl/tt_settle_cnt.sv | 35 +++
 rtl/tt_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_tt_scan_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/tt_scan_pkg.sv
// -----------------------------------------------------------------------------
// tt_scan_pkg
// Shared types and constants for the truth-table scan controller.
//   tt_state_t : scan sequencer states
//   TT_GOLDEN  : default golden truth table (bit k = y for input index k)
//   n_vec()    : number of input vectors for a given input count
// -----------------------------------------------------------------------------
package tt_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CAPTURE,
        DONE
    } tt_state_t;

    localparam logic [15:0] TT_GOLDEN = 16'hA7FF;

    function automatic int n_vec(input int n_in);
        return 2 ** n_in;
    endfunction

endpackage

// File: rtl/tt_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// tt_scan_ctrl_if
// Board-side control/status bundle of the scan controller.
//   start        : begin a scan (driven by master)
//   busy         : scan in progress
//   done         : one-cycle end-of-scan pulse
//   pass         : captured table matched the golden table
//   result_o     : captured truth table
//   err_cnt_o    : number of mismatching vectors
//   first_fail_o : lowest mismatching index
// Modports: master (button/LED side), slave (the controller).
// -----------------------------------------------------------------------------
interface tt_scan_ctrl_if #(
    parameter int N_IN = 4
) ();
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [2**N_IN-1:0]     result_o;
    logic [N_IN:0]          err_cnt_o;
    logic [N_IN-1:0]        first_fail_o;

    modport master (
        output start,
        input  busy, done, pass, result_o, err_cnt_o, first_fail_o
    );

    modport slave (
        input  start,
        output busy, done, pass, result_o, err_cnt_o, first_fail_o
    );
endinterface

// File: rtl/tt_settle_cnt.sv
// -----------------------------------------------------------------------------
// tt_settle_cnt
// Loadable down-counter timing how long each vector is held.
//   clk, rst_n : clock, async active-low reset
//   load_i     : load SETTLE-1 (asserted on the edge that enters APPLY)
//   dec_i      : count down while holding
//   zero_o     : counter has expired; last hold cycle
// -----------------------------------------------------------------------------
module tt_settle_cnt #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);
    localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= W'(SETTLE - 1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/tt_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tt_scan_ctrl
// Self-test sequencer: sweeps all 2**N_IN input vectors through an external
// combinational function, captures y for each, and compares the captured truth
// table with EXPECTED.
//   clk, rst_n : clock, async active-low reset
//   ctrl       : tt_scan_ctrl_if.slave (start/busy/done/pass/result/errors)
//   vec_o      : vector driven to the function, {a,b,c,d}, a = MSB
//   y_i        : function output
// Optional feature macro: TT_SCAN_STOP_ON_FAIL_EN -- end the scan at the first
// mismatching vector instead of completing the sweep.
// -----------------------------------------------------------------------------
module tt_scan_ctrl
    import tt_scan_pkg::*;
#(
    parameter int                    N_IN     = 4,
    parameter int                    SETTLE   = 1,
    parameter logic [2**N_IN-1:0]    EXPECTED = TT_GOLDEN
) (
    input  logic                clk,
    input  logic                rst_n,
    tt_scan_ctrl_if.slave       ctrl,
    output logic [N_IN-1:0]     vec_o,
    input  logic                y_i
);
    localparam int N_VEC = n_vec(N_IN);

    tt_state_t              state_q;
    logic [N_IN-1:0]        idx_q;
    logic [N_IN-1:0]        vec_q;
    logic [N_VEC-1:0]       result_q;
    logic [N_VEC-1:0]       result_d;
    logic [N_IN:0]          err_q;
    logic [N_IN-1:0]        ff_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;

    logic                   mismatch;
    logic                   last_vec;
    logic                   scan_end;
    logic                   enter_apply;
    logic                   settle_zero;
    logic [N_IN-1:0]        idx_d;

    assign mismatch = (y_i != EXPECTED[idx_q]);
    assign last_vec = (idx_q == N_IN'(N_VEC - 1));
    assign idx_d    = idx_q + N_IN'(1);

`ifdef TT_SCAN_STOP_ON_FAIL_EN
    assign scan_end = last_vec || mismatch;
`else
    assign scan_end = last_vec;
`endif

    assign enter_apply = ((state_q == IDLE) && ctrl.start) ||
                         ((state_q == CAPTURE) && !scan_end);

    // Truth table as it will look after this cycle's capture; pass is judged
    // on it so pass is already valid in the DONE cycle.
    always_comb begin
        result_d        = result_q;
        result_d[idx_q] = y_i;
    end

    tt_settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (enter_apply),
        .dec_i  (state_q == APPLY),
        .zero_o (settle_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            vec_q    <= '0;
            result_q <= '0;
            err_q    <= '0;
            ff_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ctrl.start) begin
                        result_q <= '0;
                        err_q    <= '0;
                        ff_q     <= '0;
                        pass_q   <= 1'b0;
                        idx_q    <= '0;
                        vec_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= APPLY;
                    end
                end
                APPLY: begin
                    if (settle_zero) state_q <= CAPTURE;
                end
                CAPTURE: begin
                    result_q <= result_d;
                    if (mismatch) begin
                        err_q <= err_q + (N_IN + 1)'(1);
                        // err_q still zero means this is the lowest failing index.
                        if (err_q == '0) ff_q <= idx_q;
                    end
                    if (scan_end) begin
                        done_q  <= 1'b1;
                        pass_q  <= (result_d == EXPECTED);
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_d;
                        vec_q   <= idx_d;
                        state_q <= APPLY;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vec_o             = vec_q;
    assign ctrl.busy         = busy_q;
    assign ctrl.done         = done_q;
    assign ctrl.pass         = pass_q;
    assign ctrl.result_o     = result_q;
    assign ctrl.err_cnt_o    = err_q;
    assign ctrl.first_fail_o = ff_q;
endmodule

// File: tb/tb_tt_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tt_scan_ctrl
// Self-checking bench for tt_scan_ctrl. Two instances: SETTLE=1 and SETTLE=3.
// A behavioural function model (golden table or y stuck at 1) feeds y_i; the
// expected scan outcome is pushed to a scoreboard at start and popped at done.
// -----------------------------------------------------------------------------
module tb_tt_scan_ctrl;
    import tt_scan_pkg::*;

    localparam int          NV   = 16;
    localparam logic [15:0] GOLD = TT_GOLDEN;
`ifdef TT_SCAN_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct {
        logic [15:0] result;
        logic        pass;
        logic [4:0]  err;
        logic [3:0]  ff;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tt_scan_ctrl_if #(.N_IN(4)) if0 ();
    tt_scan_ctrl_if #(.N_IN(4)) if1 ();

    logic [3:0] vec0, vec1;
    logic       y0, y1;
    bit         stuck = 1'b0;
    bit         sel   = 1'b0;

    assign y0 = stuck ? 1'b1 : GOLD[vec0];
    assign y1 = stuck ? 1'b1 : GOLD[vec1];

    tt_scan_ctrl #(.N_IN(4), .SETTLE(1), .EXPECTED(GOLD)) dut0 (
        .clk(clk), .rst_n(rst_n), .ctrl(if0), .vec_o(vec0), .y_i(y0)
    );
    tt_scan_ctrl #(.N_IN(4), .SETTLE(3), .EXPECTED(GOLD)) dut1 (
        .clk(clk), .rst_n(rst_n), .ctrl(if1), .vec_o(vec1), .y_i(y1)
    );

    logic        s_done, s_busy, s_pass;
    logic [15:0] s_res;
    logic [4:0]  s_err;
    logic [3:0]  s_ff, s_vec;
    assign s_done = sel ? if1.done         : if0.done;
    assign s_busy = sel ? if1.busy         : if0.busy;
    assign s_pass = sel ? if1.pass         : if0.pass;
    assign s_res  = sel ? if1.result_o     : if0.result_o;
    assign s_err  = sel ? if1.err_cnt_o    : if0.err_cnt_o;
    assign s_ff   = sel ? if1.first_fail_o : if0.first_fail_o;
    assign s_vec  = sel ? vec1             : vec0;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) if1.start = v;
        else     if0.start = v;
    endtask

    function automatic exp_t model(input bit stk, input int settle);
        exp_t e;
        logic y;
        e.result = '0;
        e.err    = '0;
        e.ff     = '0;
        e.lat    = 1 + NV * (settle + 1);
        for (int k = 0; k < NV; k++) begin
            y           = stk ? 1'b1 : GOLD[k];
            e.result[k] = y;
            if (y !== GOLD[k]) begin
                if (e.err == 0) e.ff = k[3:0];
                e.err = e.err + 5'd1;
                if (STOP) begin
                    e.lat = 1 + (k + 1) * (settle + 1);
                    break;
                end
            end
        end
        e.pass = (e.result == GOLD);
        return e;
    endfunction

    // One scan on the selected instance; optional start pokes mid-scan and in DONE.
    task automatic scan(input bit stk, input bit poke);
        exp_t e, g;
        int   k, settle, ndone;
        bit   seen;
        settle = sel ? 3 : 1;
        stuck  = stk;
        e      = model(stk, settle);
        sb.push_back(e);
        @(negedge clk); set_start(1'b1);
        @(negedge clk); set_start(1'b0);
        k    = 1;
        seen = 1'b0;
        check("busy_first_apply", s_busy, 1);
        while (k <= 300 && !seen) begin
            if (s_done) begin
                seen = 1'b1;
            end else begin
                if (k - 1 < NV * (settle + 1))
                    check($sformatf("vec_k%0d", k), s_vec, (k - 1) / (settle + 1));
                if (poke && k == 11) set_start(1'b1);
                if (poke && k == 12) set_start(1'b0);
                @(negedge clk);
                k++;
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            void'(sb.pop_front());
        end else begin
            g = sb.pop_front();
            check("done_latency", k, g.lat);
            check("result", s_res, g.result);
            check("pass", s_pass, g.pass);
            check("err_cnt", s_err, g.err);
            check("first_fail", s_ff, g.ff);
            check("busy_in_done", s_busy, 1);
        end
        if (poke) set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check("done_one_cycle", s_done, 0);
        check("busy_after_done", s_busy, 0);
        if (poke) begin
            ndone = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (s_done || s_busy) ndone++;
            end
            check("no_retrigger", ndone, 0);
        end
    endtask

    initial begin
        int   k, ndone, last;
        exp_t e;
        if0.start = 1'b0;
        if1.start = 1'b0;
        #12;
        check("rst_vec", vec0, 0);
        check("rst_result", if0.result_o, 0);
        check("rst_err", if0.err_cnt_o, 0);
        check("rst_ff", if0.first_fail_o, 0);
        check("rst_flags", {if0.busy, if0.done, if0.pass}, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        sel = 1'b0; scan(1'b0, 1'b0);   // golden function
        sel = 1'b0; scan(1'b1, 1'b0);   // y stuck at 1
        repeat (3) @(negedge clk);
        check("pass_held", if0.pass, model(1'b1, 1).pass);
        sel = 1'b1; scan(1'b0, 1'b0);   // SETTLE = 3
        sel = 1'b0; scan(1'b0, 1'b1);   // ignored start pulses

        // Reset in the middle of the scan, while vector 7 is applied.
        sel = 1'b0; stuck = 1'b0;
        sb.push_back(model(1'b0, 1));
        @(negedge clk); if0.start = 1'b1;
        @(negedge clk); if0.start = 1'b0;
        k = 0;
        while (vec0 != 4'd7 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reach_idx7", vec0, 7);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", if0.busy, 0);
        check("midrst_vec", vec0, 0);
        check("midrst_result", if0.result_o, 0);
        check("midrst_done", if0.done, 0);
        void'(sb.pop_back());
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        scan(1'b0, 1'b0);

        // start held high for 100 cycles: back-to-back scans.
        e = model(1'b0, 1);
        stuck = 1'b0;
        @(negedge clk); if0.start = 1'b1;
        ndone = 0;
        last  = -1;
        for (int c = 1; c <= 140; c++) begin
            @(negedge clk);
            if (if0.done) begin
                ndone++;
                check("b2b_pass", if0.pass, 1);
                check("b2b_result", if0.result_o, e.result);
                if (last < 0) check("b2b_first", c, e.lat);
                else          check("b2b_interval", c - last, e.lat + 1);
                last = c;
            end
            if (c == 100) if0.start = 1'b0;
        end
        check("b2b_count", ndone, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
